// File: rtl/encoder_16to4_reg.sv
// Registered 16-to-4 priority encoder. The highest set bit of d wins.
// valid flags any set bit and multi flags two or more set bits; all outputs have one cycle of latency.
module encoder_16to4_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d,
   output logic [3:0]  o,
   output logic        valid,
   output logic        multi
);

   logic [3:0] o_q, o_d;
   logic       valid_q, valid_d;
   logic       multi_q, multi_d;

   // Ascending scan so the last hit (highest index) sets o_d. A hit while
   // valid_d is already set means a second bit is present, which is a true two-hot detect.
   always_comb begin
      o_d     = 4'd0;
      valid_d = 1'b0;
      multi_d = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (d[k]) begin
            multi_d = multi_d | valid_d;
            valid_d = 1'b1;
            o_d     = 4'(k);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_q     <= 4'd0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         o_q     <= o_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
      end
   end

   assign o     = o_q;
   assign valid = valid_q;
   assign multi = multi_q;

endmodule

// File: tb/tb_encoder_16to4_reg.sv
// Self-checking bench for encoder_16to4_reg: directed scenarios plus randomized
// words scored against a popcount/magnitude reference model.
module tb_encoder_16to4_reg;

   logic        clk;
   logic        rst;
   logic [15:0] d;
   logic [3:0]  o;
   logic        valid;
   logic        multi;

   int n_checks = 0;
   int n_errors = 0;
   logic [5:0] exp_q[$];

   encoder_16to4_reg dut (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .o     (o),
      .valid (valid),
      .multi (multi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: index = largest k with v >= 2^k; flags come from the popcount.
   function automatic logic [5:0] model(input logic [15:0] v);
      int cnt;
      int hi;
      logic [31:0] hv;
      cnt = $countones(v);
      hi  = 0;
      for (int k = 0; k < 16; k++)
         if (32'(v) >= (32'd1 << k)) hi = k;
      hv = 32'(hi);
      return {hv[3:0], cnt >= 1, cnt >= 2};
   endfunction

   task automatic drive_cycle(input logic [15:0] v);
      @(negedge clk);
      d = v;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      d   = 16'hFFFF;
      #1;
      n_checks++;
      if ({o, valid, multi} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_initial o=%0d valid=%b multi=%b expected 0/0/0", o, valid, multi);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({o, valid, multi} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_clocked o=%0d valid=%b multi=%b expected 0/0/0", o, valid, multi);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_walking_one();
      logic [5:0] e;
      for (int k = 0; k < 16; k++) begin
         drive_cycle(16'd1 << k);
         e = model(16'd1 << k);
         n_checks++;
         if ({o, valid, multi} !== e || o !== 4'(k) || multi !== 1'b0) begin
            n_errors++;
            $display("FAIL walking_one k=%0d o=%0d valid=%b multi=%b expected o=%0d valid=1 multi=0",
                     k, o, valid, multi, k);
         end
      end
   endtask

   task automatic test_zero();
      drive_cycle(16'h0000);
      n_checks++;
      if (o !== 4'd0 || valid !== 1'b0 || multi !== 1'b0) begin
         n_errors++;
         $display("FAIL zero_input o=%0d valid=%b multi=%b expected 0/0/0", o, valid, multi);
      end
   endtask

   task automatic test_priority();
      logic [15:0] words[3];
      logic [5:0]  want[3];
      words = '{16'h8001, 16'h0006, 16'hFFFF};
      want  = '{{4'd15, 1'b1, 1'b1}, {4'd2, 1'b1, 1'b1}, {4'd15, 1'b1, 1'b1}};
      for (int i = 0; i < 3; i++) begin
         drive_cycle(words[i]);
         n_checks++;
         if ({o, valid, multi} !== want[i]) begin
            n_errors++;
            $display("FAIL priority d=%h got o=%0d valid=%b multi=%b expected o=%0d valid=%b multi=%b",
                     words[i], o, valid, multi, want[i][5:2], want[i][1], want[i][0]);
         end
      end
   endtask

   task automatic test_async_reset();
      drive_cycle(16'h0200);
      n_checks++;
      if (o !== 4'd9 || valid !== 1'b1) begin
         n_errors++;
         $display("FAIL async_reset_pre o=%0d valid=%b expected o=9 valid=1", o, valid);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({o, valid, multi} !== 6'b0) begin
         n_errors++;
         $display("FAIL async_reset_immediate o=%0d valid=%b multi=%b expected 0/0/0", o, valid, multi);
      end
      d = 16'h0400;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({o, valid, multi} !== 6'b0) begin
         n_errors++;
         $display("FAIL async_reset_hold o=%0d valid=%b multi=%b expected 0/0/0", o, valid, multi);
      end
   endtask

   task automatic test_reset_release();
      @(negedge clk);
      d   = 16'h0100;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (o !== 4'd8 || valid !== 1'b1 || multi !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release o=%0d valid=%b multi=%b expected o=8 valid=1 multi=0", o, valid, multi);
      end
   endtask

   task automatic test_latency();
      drive_cycle(16'h0010);
      n_checks++;
      if (o !== 4'd4) begin
         n_errors++;
         $display("FAIL latency_first o=%0d expected 4", o);
      end
      #2;
      d = 16'h2000;
      #1;
      n_checks++;
      if (o !== 4'd4) begin
         n_errors++;
         $display("FAIL latency_hold o=%0d expected 4", o);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (o !== 4'd13 || valid !== 1'b1 || multi !== 1'b0) begin
         n_errors++;
         $display("FAIL latency_update o=%0d valid=%b multi=%b expected o=13 valid=1 multi=0", o, valid, multi);
      end
   endtask

   task automatic test_random();
      logic [15:0] v;
      logic [5:0]  e;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: v = 16'($urandom);
            1: v = 16'd1 << $urandom_range(0, 15);
            2: v = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            default: v = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom) & 16'($urandom);
         endcase
         exp_q.push_back(model(v));
         drive_cycle(v);
         e = exp_q.pop_front();
         n_checks++;
         if ({o, valid, multi} !== e) begin
            n_errors++;
            $display("FAIL random d=%h got o=%0d valid=%b multi=%b expected o=%0d valid=%b multi=%b",
                     v, o, valid, multi, e[5:2], e[1], e[0]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      d   = 16'h0000;
      test_reset();
      test_walking_one();
      test_zero();
      test_priority();
      test_latency();
      test_async_reset();
      test_reset_release();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
